// File: rtl/apb2axi_txn_ctrl_if.sv
// Bus bundle for the APB-to-AXI transaction controller.
// Carries the APB slave port and the single-beat AXI master port side by side;
// the controller uses apb_slave + axi_master, an environment uses the mirrors.
interface apb2axi_txn_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // APB
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // AXI write address / data / response
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;

    // AXI read address / data
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic              RREADY;
    logic [1:0]        RRESP;

    modport apb_slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

    modport apb_master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport axi_master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RVALID, RRESP
    );

    modport axi_slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RVALID, RRESP
    );
endinterface

// File: rtl/apb2axi_txn_ctrl.sv
// APB-to-AXI transaction controller.
// Each APB access becomes one single-beat AXI write (AW+W, then B) or read
// (AR, then R). PREADY is held low until the AXI response returns. A response
// timeout ends the APB transfer with PSLVERR and leaves a stale flag so the
// late beat is drained and discarded before the next access is accepted.
module apb2axi_txn_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    apb2axi_txn_ctrl_if.apb_slave        apb,
    apb2axi_txn_ctrl_if.axi_master       axi
);

    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit               TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_e;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic [DATA_W-1:0] prdata_q,  prdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q,  wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q,  bready_d;
    logic              rready_q,  rready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;
    logic              err_q,     err_d;
    logic              stale_b_q, stale_b_d;
    logic              stale_r_q, stale_r_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic aw_hs;
    logic w_hs;
    logic to_hit;
    logic unused_resp_bits;

    assign aw_hs  = awvalid_q && axi.AWREADY;
    assign w_hs   = wvalid_q && axi.WREADY;
    assign to_hit = TO_EN && (cnt_q == TO_LAST);

    // EXOKAY (RESP[0]) carries no error meaning here
    assign unused_resp_bits = axi.BRESP[0] ^ axi.RRESP[0];

    // Next-state and next-output decode for the whole controller
    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        araddr_d  = araddr_q;
        prdata_d  = prdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        stale_b_d = stale_b_q;
        stale_r_d = stale_r_q;
        cnt_d     = cnt_q;

        // A late response to a timed-out transfer is swallowed here
        if (stale_b_q && axi.BVALID && bready_q) begin
            stale_b_d = 1'b0;
        end
        if (stale_r_q && axi.RVALID && rready_q) begin
            stale_r_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (apb.PSEL && apb.PENABLE && !stale_b_q && !stale_r_q) begin
                    err_d = 1'b0;
                    if (apb.PWRITE) begin
                        awaddr_d  = apb.PADDR;
                        wdata_d   = apb.PWDATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = apb.PADDR;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    cnt_d   = '0;
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                if (axi.BVALID) begin
                    err_d   = axi.BRESP[1];
                    state_d = DONE;
                end else if (to_hit) begin
                    err_d     = 1'b1;
                    stale_b_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RD_REQ: begin
                if (axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (axi.RVALID) begin
                    prdata_d = axi.RDATA;
                    err_d    = axi.RRESP[1];
                    state_d  = DONE;
                end else if (to_hit) begin
                    prdata_d  = '0;
                    err_d     = 1'b1;
                    stale_r_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Response-channel READY is high while waiting or while draining
        bready_d = stale_b_d || (state_d == WR_RESP);
        rready_d = stale_r_d || (state_d == RD_RESP);
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            araddr_q  <= '0;
            prdata_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            stale_b_q <= 1'b0;
            stale_r_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            araddr_q  <= araddr_d;
            prdata_q  <= prdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            stale_b_q <= stale_b_d;
            stale_r_q <= stale_r_d;
            cnt_q     <= cnt_d;
        end
    end

    assign axi.AWADDR  = awaddr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = (state_q == DONE);
    assign apb.PSLVERR = (state_q == DONE) && err_q;

endmodule
